// File: rtl/mag_seq_cmp.sv
// -----------------------------------------------------------------------------
// mag_seq_cmp -- nibble-serial magnitude comparator sequencer
//
// Latches two WIDTH-bit operands and resolves A vs B one 4-bit digit per clock,
// most significant digit first. The gt/eq/lt cascade state is carried in
// registers between clocks instead of through a chain of comparator stages.
//
// Parameters
//   WIDTH   operand width, multiple of 4, >= 4
//   SIGNED  0: unsigned compare, 1: two's-complement compare
//
// Ports
//   sys_clk    in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   cmd_valid  in   request a compare of a/b
//   cmd_ready  out  high only in IDLE
//   a, b       in   operands, sampled on the accept edge only
//   res_valid  out  gt/eq/lt hold a final result (DONE)
//   res_ready  in   consumer takes the result
//   gt/eq/lt   out  A>B / A==B / A<B
//   busy       out  high in RUN or DONE
//
// Configuration macro
//   MAG_SEQ_EARLY_EXIT_EN  when defined, RUN ends on the edge that resolves the
//                          first differing digit; otherwise latency is always
//                          WIDTH/4 cycles.
// -----------------------------------------------------------------------------
module mag_seq_cmp #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N-1:0][3:0]   r_a;
    logic [N-1:0][3:0]   r_b;
    logic [CW-1:0]       r_cnt;
    logic                r_gt;
    logic                r_eq;
    logic                r_lt;
    logic [3:0]          w_da;
    logic [3:0]          w_db;
    logic                w_diff;
    logic                w_last;

    // Current digit pair. For a signed compare the top digit has its sign bit
    // flipped, which maps two's-complement ordering onto unsigned ordering.
    always_comb begin
        w_da = r_a[r_cnt];
        w_db = r_b[r_cnt];
        if (SIGNED && (r_cnt == CW'(N - 1))) begin
            w_da[3] = ~w_da[3];
            w_db[3] = ~w_db[3];
        end
    end

    assign w_diff = (w_da != w_db);
    assign w_last = (r_cnt == '0);

    // State register
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next = S_RUN;
            end
            S_RUN: begin
`ifdef MAG_SEQ_EARLY_EXIT_EN
                // Stop as soon as the first differing digit settles the answer.
                if (w_last || (r_eq && w_diff)) w_next = S_DONE;
`else
                if (w_last) w_next = S_DONE;
`endif
            end
            S_DONE: begin
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand, counter and cascade registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= CW'(N - 1);
                        r_gt  <= 1'b0;
                        r_eq  <= 1'b1;
                        r_lt  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Only the first differing digit decides; later digits
                    // leave an already-resolved cascade untouched.
                    if (r_eq && w_diff) begin
                        r_gt <= (w_da > w_db);
                        r_lt <= (w_da < w_db);
                        r_eq <= 1'b0;
                    end
                    if (!w_last) r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;

endmodule

// File: tb/tb_mag_seq_cmp.sv
module tb_mag_seq_cmp;

    logic        sys_clk   = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;

    logic u_cmd_ready, u_res_valid, u_gt, u_eq, u_lt, u_busy;
    logic s_cmd_ready, s_res_valid, s_gt, s_eq, s_lt, s_busy;

    mag_seq_cmp #(.WIDTH(32), .SIGNED(1'b0)) u_dut (
        .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(u_cmd_ready),
        .a(a), .b(b), .res_valid(u_res_valid), .res_ready(res_ready),
        .gt(u_gt), .eq(u_eq), .lt(u_lt), .busy(u_busy));

    mag_seq_cmp #(.WIDTH(32), .SIGNED(1'b1)) s_dut (
        .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .a(a), .b(b), .res_valid(s_res_valid), .res_ready(res_ready),
        .gt(s_gt), .eq(s_eq), .lt(s_lt), .busy(s_busy));

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic ugt, ueq, ult, sgt, seq, slt;
        int   acc;
        int   lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   last_acc = -1;
    int   last_lat = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] ta, input logic [31:0] tb_);
`ifdef MAG_SEQ_EARLY_EXIT_EN
        for (int k = 0; k < 8; k++) begin
            if (ta[31-4*k -: 4] != tb_[31-4*k -: 4]) return k + 1;
        end
        return 8;
`else
        return 8;
`endif
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input bit track_gap);
        exp_t x;
        int   n = 0;
        while (!u_cmd_ready && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 200) chk("cmd_ready_timeout", 0, 1);
        a = ta;
        b = tb_;
        cmd_valid = 1'b1;
        x.ugt = (ta > tb_);
        x.ueq = (ta == tb_);
        x.ult = (ta < tb_);
        x.sgt = ($signed(ta) > $signed(tb_));
        x.seq = (ta == tb_);
        x.slt = ($signed(ta) < $signed(tb_));
        x.acc = cyc + 1;
        x.lat = exp_lat(ta, tb_);
        if (track_gap && last_acc >= 0) chk("b2b_accept_gap", x.acc - last_acc, last_lat + 2);
        last_acc = x.acc;
        last_lat = x.lat;
        q.push_back(x);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !u_cmd_ready) && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
    endtask

    // Monitor: compares each new result against the scoreboard head.
    bit prev_rv = 1'b0;
    always @(negedge sys_clk) begin
        if (reset) begin
            prev_rv = 1'b0;
        end else begin
            if (u_res_valid && !prev_rv) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("u_gt", u_gt, e.ugt);
                    chk("u_eq", u_eq, e.ueq);
                    chk("u_lt", u_lt, e.ult);
                    chk("s_res_valid", s_res_valid, 1);
                    chk("s_gt", s_gt, e.sgt);
                    chk("s_eq", s_eq, e.seq);
                    chk("s_lt", s_lt, e.slt);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("onehot", u_gt + u_eq + u_lt, 1);
                end
            end
            prev_rv = u_res_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_cmd_ready", u_cmd_ready, 1);
        chk("rst_res_valid", u_res_valid, 0);
        chk("rst_gteqlt", {u_gt, u_eq, u_lt}, 0);
        chk("rst_busy", u_busy, 0);
        reset = 1'b0;
        @(negedge sys_clk);

        // Directed vectors
        issue(32'h12345678, 32'h12345679, 0); drain();
        issue(32'h80000000, 32'h7FFFFFFF, 0); drain();
        issue(32'hDEADBEEF, 32'hDEADBEEF, 0); drain();
        issue(32'h00000000, 32'h00000000, 0); drain();

        // Backpressure with ignored commands during RUN/DONE
        res_ready = 1'b0;
        issue(32'h00000010, 32'h00000001, 0);
        a = 32'hFFFFFFFF; b = 32'h0; cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        begin
            int n = 0;
            while (!u_res_valid && n < 50) begin
                @(negedge sys_clk);
                n++;
            end
            if (n >= 50) chk("res_valid_timeout", 0, 1);
        end
        a = 32'h0; b = 32'hFFFFFFFF; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("bp_res_valid", u_res_valid, 1);
            chk("bp_gteqlt", {u_gt, u_eq, u_lt}, 3'b100);
            chk("bp_cmd_ready", u_cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge sys_clk);
        chk("hs_res_valid", u_res_valid, 0);
        chk("hs_retain", {u_gt, u_eq, u_lt}, 3'b100);
        chk("hs_cmd_ready", u_cmd_ready, 1);

        // Reset mid-operation
        issue(32'h12345678, 32'h12345670, 0);
        repeat (2) @(negedge sys_clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_res_valid", u_res_valid, 0);
        chk("mid_rst_gteqlt", {u_gt, u_eq, u_lt}, 0);
        chk("mid_rst_busy", u_busy, 0);
        chk("mid_rst_cmd_ready", u_cmd_ready, 1);
        q.delete();
        @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
        issue(32'h5, 32'h3, 0); drain();

        // Back-to-back random pairs
        last_acc = -1;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            issue(ra, rb, 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
